// File: rtl/riscv_mc_seq_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: stage encodings,
// the NOP instruction and the default reset vector.
package riscv_mc_seq_pkg;

    // Sequencer stages, 3-bit encoding
    typedef enum logic [2:0] {
        SEQ_FETCH  = 3'd0,
        SEQ_FWAIT  = 3'd1,
        SEQ_DECODE = 3'd2,
        SEQ_EXEC   = 3'd3,
        SEQ_MEM    = 3'd4,
        SEQ_MWAIT  = 3'd5,
        SEQ_WB     = 3'd6,
        SEQ_HALT   = 3'd7
    } seq_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

    // RV32I without compressed instructions needs word-aligned targets
    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/riscv_mc_seq_mem_hs.sv
// req/gnt/rvalid tracker for one memory port. The request is only driven
// while the owner asks for it and reset is released; a response is only
// accepted while a granted request that expects data is outstanding, so
// stray rvalids (e.g. from before a reset) fall on the floor.
module riscv_mc_seq_mem_hs (
    input  logic clk,
    input  logic rst,
    input  logic req_en,
    input  logic expect_rsp,
    input  logic gnt,
    input  logic rvalid,
    output logic req,
    output logic accepted,
    output logic rsp_valid
);

    logic pending;

    // keep the request quiet while reset is held
    assign req       = req_en && rst;
    assign accepted  = req && gnt;
    assign rsp_valid = pending && rvalid;

    // outstanding-response flag: set on a grant that expects data, cleared by its rvalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 1'b0;
        end else if (accepted && expect_rsp) begin
            pending <= 1'b1;
        end else if (rsp_valid) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_mc_seq.sv
// Multi-cycle sequencer for the RV32I core. Owns PC, instruction register
// and the stage FSM; talks to handshaked instruction/data memories so any
// memory latency is tolerated. The combinational ID/EX datapath is fed from
// ir_o/pc_o and returns next PC, effective address and store data.
// Optional feature: define RISCV_PERF_CNT_EN to add mcycle_o/minstret_o.
module riscv_mc_seq
    import riscv_mc_seq_pkg::*;
#(
    parameter int                    XLEN         = 32,
    parameter int                    PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    // instruction memory
    output logic                inst_req_o,
    output logic [PC_WIDTH-1:0] inst_addr_o,
    input  logic                inst_gnt_i,
    input  logic                inst_rvalid_i,
    input  logic [31:0]         inst_i,
    // data memory
    output logic                data_req_o,
    output logic                data_we_o,
    output logic [XLEN-1:0]     data_addr_o,
    output logic [XLEN-1:0]     data_o,
    input  logic                data_gnt_i,
    input  logic                data_rvalid_i,
    input  logic [XLEN-1:0]     data_i,
    // decoder
    input  logic                dec_load_i,
    input  logic                dec_store_i,
    input  logic                dec_regwrite_i,
    input  logic                dec_illegal_i,
    // execute
    input  logic [PC_WIDTH-1:0] ex_next_pc_i,
    input  logic [XLEN-1:0]     ex_addr_i,
    input  logic [XLEN-1:0]     ex_wdata_i,
    // to datapath / status
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [31:0]         ir_o,
    output logic [XLEN-1:0]     load_data_o,
    output logic                rf_we_o,
    output logic                halt_o
`ifdef RISCV_PERF_CNT_EN
    ,
    output logic [63:0]         mcycle_o,
    output logic [63:0]         minstret_o
`endif
);

    seq_state_t          state, state_nxt;
    logic [PC_WIDTH-1:0] next_pc_q;
    logic                inst_acc, inst_rsp;
    logic                data_acc, data_rsp;

    assign inst_addr_o = pc_o;

    riscv_mc_seq_mem_hs u_inst_hs (
        .clk        (clk),
        .rst        (rst),
        .req_en     (state == SEQ_FETCH),
        .expect_rsp (1'b1),
        .gnt        (inst_gnt_i),
        .rvalid     (inst_rvalid_i),
        .req        (inst_req_o),
        .accepted   (inst_acc),
        .rsp_valid  (inst_rsp)
    );

    // stores complete on grant; only loads wait for read data
    riscv_mc_seq_mem_hs u_data_hs (
        .clk        (clk),
        .rst        (rst),
        .req_en     (state == SEQ_MEM),
        .expect_rsp (dec_load_i),
        .gnt        (data_gnt_i),
        .rvalid     (data_rvalid_i),
        .req        (data_req_o),
        .accepted   (data_acc),
        .rsp_valid  (data_rsp)
    );

    // stage register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEQ_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // next-stage selection and per-stage strobes
    always_comb begin
        state_nxt = state;
        rf_we_o   = 1'b0;
        halt_o    = 1'b0;
        data_we_o = 1'b0;
        case (state)
            SEQ_FETCH: begin
                if (inst_acc) state_nxt = SEQ_FWAIT;
            end
            SEQ_FWAIT: begin
                if (inst_rsp) state_nxt = SEQ_DECODE;
            end
            SEQ_DECODE: begin
                state_nxt = dec_illegal_i ? SEQ_HALT : SEQ_EXEC;
            end
            SEQ_EXEC: begin
                if (pc_misaligned(ex_next_pc_i[1:0])) begin
                    state_nxt = SEQ_HALT;
                end else if (dec_load_i || dec_store_i) begin
                    state_nxt = SEQ_MEM;
                end else begin
                    state_nxt = SEQ_WB;
                end
            end
            SEQ_MEM: begin
                data_we_o = dec_store_i;
                if (data_acc) state_nxt = dec_store_i ? SEQ_WB : SEQ_MWAIT;
            end
            SEQ_MWAIT: begin
                if (data_rsp) state_nxt = SEQ_WB;
            end
            SEQ_WB: begin
                rf_we_o   = dec_regwrite_i;
                state_nxt = SEQ_FETCH;
            end
            SEQ_HALT: begin
                halt_o = 1'b1;
            end
            default: state_nxt = SEQ_FETCH;
        endcase
    end

    // architectural latches: IR on fetch data, EX results in EXEC, load data, PC in WB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_o        <= RESET_VECTOR;
            ir_o        <= NOP_INSN;
            next_pc_q   <= RESET_VECTOR;
            data_addr_o <= '0;
            data_o      <= '0;
            load_data_o <= '0;
        end else begin
            if (state == SEQ_FWAIT && inst_rsp) ir_o <= inst_i;
            if (state == SEQ_EXEC) begin
                next_pc_q   <= ex_next_pc_i;
                data_addr_o <= ex_addr_i;
                data_o      <= ex_wdata_i;
            end
            if (state == SEQ_MWAIT && data_rsp) load_data_o <= data_i;
            // the sequencer never adds; wrap comes from the EX result itself
            if (state == SEQ_WB) pc_o <= next_pc_q;
        end
    end

`ifdef RISCV_PERF_CNT_EN
    // free-running cycle count (frozen in HALT) and retired-instruction count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle_o   <= '0;
            minstret_o <= '0;
        end else begin
            if (state != SEQ_HALT) mcycle_o   <= mcycle_o + 64'd1;
            if (state == SEQ_WB)   minstret_o <= minstret_o + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_mc_seq.sv
// Scoreboard bench for riscv_mc_seq: stimulus pushes expected fetch, data
// and write-back events; a negedge monitor pops and compares them.
module tb_riscv_mc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req_o, inst_gnt_i = 0, inst_rvalid_i = 0;
    logic [31:0] inst_addr_o, inst_i = 0;
    logic        data_req_o, data_we_o, data_gnt_i = 0, data_rvalid_i = 0;
    logic [31:0] data_addr_o, data_o, data_i = 0;
    logic        dec_load_i = 0, dec_store_i = 0, dec_regwrite_i = 0, dec_illegal_i = 0;
    logic [31:0] ex_next_pc_i = 0, ex_addr_i = 0, ex_wdata_i = 0;
    logic [31:0] pc_o, ir_o, load_data_o;
    logic        rf_we_o, halt_o;

    riscv_mc_seq dut (
        .clk(clk), .rst(rst),
        .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o), .inst_gnt_i(inst_gnt_i),
        .inst_rvalid_i(inst_rvalid_i), .inst_i(inst_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
        .data_o(data_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_i(data_i),
        .dec_load_i(dec_load_i), .dec_store_i(dec_store_i), .dec_regwrite_i(dec_regwrite_i),
        .dec_illegal_i(dec_illegal_i),
        .ex_next_pc_i(ex_next_pc_i), .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i),
        .pc_o(pc_o), .ir_o(ir_o), .load_data_o(load_data_o), .rf_we_o(rf_we_o), .halt_o(halt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] pc; logic chk_ld; logic [31:0] ld; } wb_t;
    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; } dm_t;

    logic [31:0] fq[$];
    dm_t         dq[$];
    wb_t         wq[$];
    int          tests = 0, failed = 0;
    logic [31:0] mpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pop expectations when the DUT presents an event
    always @(negedge clk) begin
        if (inst_req_o && inst_gnt_i) begin
            if (fq.size() == 0) chk("unexpected_fetch", {32'h0, inst_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("fetch_addr", {32'h0, inst_addr_o}, {32'h0, fq.pop_front()});
        end
        if (data_req_o && data_gnt_i) begin
            if (dq.size() == 0) chk("unexpected_data_req", {32'h0, data_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                dm_t d;
                d = dq.pop_front();
                chk("data_addr", {32'h0, data_addr_o}, {32'h0, d.addr});
                chk("data_wdata", {32'h0, data_o}, {32'h0, d.wdata});
                chk("data_we", {63'h0, data_we_o}, {63'h0, d.we});
            end
        end
        if (rf_we_o) begin
            if (wq.size() == 0) chk("unexpected_rf_we", {32'h0, pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                wb_t w;
                w = wq.pop_front();
                chk("wb_cycle", 64'(cyc), 64'(w.cyc));
                chk("wb_pc", {32'h0, pc_o}, {32'h0, w.pc});
                if (w.chk_ld) chk("wb_load_data", {32'h0, load_data_o}, {32'h0, w.ld});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        inst_gnt_i = 0; inst_rvalid_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
        dec_load_i = 0; dec_store_i = 0; dec_regwrite_i = 0; dec_illegal_i = 0;
        tick();
        chk("rst_pc", {32'h0, pc_o}, 64'h0);
        chk("rst_ir", {32'h0, ir_o}, 64'h13);
        chk("rst_reqs", {60'h0, inst_req_o, data_req_o, rf_we_o, halt_o}, 64'h0);
        chk("rst_data", {data_addr_o, data_o}, 64'h0);
        chk("rst_load_data", {32'h0, load_data_o}, 64'h0);
        rst = 1'b1;
        mpc = 32'h0;
    endtask

    // fetch handshake with ig cycles of gnt delay and rvalid ir cycles after gnt
    task automatic fetch(input logic [31:0] ins, input int ig, input int ir);
        fq.push_back(mpc);
        for (int i = 0; i < ig; i++) begin
            chk("fetch_req_held", {31'h0, inst_req_o, inst_addr_o}, {31'h0, 1'b1, mpc});
            tick();
        end
        inst_gnt_i = 1; tick(); inst_gnt_i = 0;
        repeat (ir - 1) tick();
        inst_rvalid_i = 1; inst_i = ins; tick(); inst_rvalid_i = 0;
        chk("ir_latched", {32'h0, ir_o}, {32'h0, ins});
    endtask

    // kind: 0 ALU/branch, 1 store, 2 load
    task automatic run_instr(input logic [31:0] ins, input int kind, input int ig, input int ir,
                             input int dg, input int dr, input logic [31:0] npc,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] ldata, input logic rw);
        int  lat, n;
        wb_t w;
        dm_t d;
        dec_load_i = (kind == 2); dec_store_i = (kind == 1);
        dec_regwrite_i = rw; dec_illegal_i = 0;
        ex_next_pc_i = npc; ex_addr_i = addr; ex_wdata_i = wdata;
        lat = 5 + ig + (ir - 1) + ((kind == 1) ? 1 + dg : (kind == 2) ? 2 + dg + dr - 1 : 0);
        if (rw) begin
            w.cyc = cyc + lat - 1; w.pc = mpc; w.chk_ld = (kind == 2); w.ld = ldata;
            wq.push_back(w);
        end
        fetch(ins, ig, ir);
        if (kind != 0) begin
            tick(); tick();
            d.addr = addr; d.wdata = wdata; d.we = (kind == 1);
            dq.push_back(d);
            for (int i = 0; i < dg; i++) begin
                chk("data_req_held", {data_req_o, data_we_o, 30'h0, data_addr_o},
                    {1'b1, kind == 1, 30'h0, addr});
                chk("data_wdata_held", {32'h0, data_o}, {32'h0, wdata});
                tick();
            end
            data_gnt_i = 1; tick(); data_gnt_i = 0;
            if (kind == 2) begin
                repeat (dr - 1) tick();
                data_rvalid_i = 1; data_i = ldata; tick(); data_rvalid_i = 0;
            end
        end
        n = 0;
        while (!inst_req_o && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("refetch_timeout", 64'(n), 64'h0);
        mpc = npc;
        chk("pc_next", {32'h0, pc_o}, {32'h0, mpc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        // ALU at 0x0, 5-cycle latency
        run_instr(32'h0010_0093, 0, 0, 1, 0, 0, 32'h4, 32'h0, 32'h0, 32'h0, 1'b1);
        // ALU with fetch grant delayed 3 cycles: 8-cycle latency
        run_instr(32'h0020_8113, 0, 3, 1, 0, 0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b1);
        // taken branch, no write-back
        run_instr(32'h0200_0c63, 0, 0, 2, 0, 0, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0);
        // store with data grant delayed 2 cycles
        run_instr(32'h1011_2023, 1, 0, 1, 2, 0, 32'h44, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0);
        // load, rvalid 4 cycles after grant
        run_instr(32'h1000_a283, 2, 0, 1, 1, 4, 32'h48, 32'h200, 32'h0, 32'h1234_5678, 1'b1);
        // load with minimal latency: 7 cycles
        run_instr(32'h0040_a303, 2, 0, 1, 0, 1, 32'h4C, 32'h204, 32'h0, 32'hA5A5_5A5A, 1'b1);
        // stray inst rvalid in FETCH and data gnt without request are ignored
        inst_rvalid_i = 1; inst_i = 32'hFFFF_FFFF; data_gnt_i = 1;
        tick();
        inst_rvalid_i = 0; data_gnt_i = 0;
        chk("stray_ir", {32'h0, ir_o}, 64'h0040_a303);
        chk("stray_state", {30'h0, inst_req_o, data_req_o, pc_o}, {30'h0, 2'b10, 32'h4C});
        // PC loads straight from EX, including targets near the top of the space
        run_instr(32'h0010_0093, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 1'b1);
        run_instr(32'h0010_0093, 0, 1, 1, 0, 0, 32'h0000_0000, 32'h0, 32'h0, 32'h0, 1'b1);

        // reset during MWAIT, then a stray data rvalid
        dec_load_i = 1; dec_store_i = 0; dec_regwrite_i = 1; dec_illegal_i = 0;
        ex_next_pc_i = 32'h4; ex_addr_i = 32'h300; ex_wdata_i = 0;
        fetch(32'h3000_a383, 0, 1);
        tick(); tick();
        begin
            dm_t d;
            d.addr = 32'h300; d.wdata = 32'h0; d.we = 1'b0;
            dq.push_back(d);
        end
        data_gnt_i = 1; tick(); data_gnt_i = 0;
        tick();
        do_reset();
        data_rvalid_i = 1; data_i = 32'hBAD0_BAD0; tick(); data_rvalid_i = 0;
        chk("after_rst_pc", {32'h0, pc_o}, 64'h0);
        chk("after_rst_load", {32'h0, load_data_o}, 64'h0);
        chk("after_rst_refetch", {63'h0, inst_req_o}, 64'h1);

        // illegal instruction halts; PC frozen, grants ignored
        run_instr(32'h0010_0093, 0, 0, 1, 0, 0, 32'h20, 32'h0, 32'h0, 32'h0, 1'b1);
        dec_illegal_i = 1; dec_regwrite_i = 1; dec_load_i = 0; dec_store_i = 0;
        fetch(32'hFFFF_FFFF, 0, 1);
        tick();
        inst_gnt_i = 1; data_gnt_i = 1;
        for (int i = 0; i < 3; i++) begin
            chk("ill_halt", {61'h0, halt_o, inst_req_o, data_req_o}, 64'h4);
            chk("ill_pc", {32'h0, pc_o}, 64'h20);
            tick();
        end
        inst_gnt_i = 0; data_gnt_i = 0;
        do_reset();

        // misaligned branch target halts without write-back
        dec_illegal_i = 0; dec_regwrite_i = 1; ex_next_pc_i = 32'h6;
        fetch(32'h0060_006F, 0, 1);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("mis_halt", {61'h0, halt_o, inst_req_o, data_req_o}, 64'h4);
            chk("mis_pc", {32'h0, pc_o}, 64'h0);
            tick();
        end

        chk("queues_drained", 64'(fq.size() + dq.size() + wq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
